game_ctrl: RTL and testbench

- Frame-level sequencer for the paddle game. Turns VGA vsync into a per-frame update strobe and conditions the raw left/right buttons.
- Runs the serve/play/miss/game-over state machine and keeps lives and score.
- Drives the paddle's left/right/update inputs and the ball block's hold/run controls.
- Sits between the board I/O and the paddle/ball datapath blocks.

---
 rtl/game_ctrl_pkg.sv | 27 ++
 rtl/game_ctrl_btn_cond.sv | 52 +++++
 rtl/game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_game_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared state encoding and playfield constants for the paddle game
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } game_state_t;

    localparam int SCREEN_WIDTH     = 640;
    localparam int PADDLE_MIN_Y     = 440;
    localparam int PADDLE_MAX_Y     = 460;
    localparam int DEF_LIVES_INIT   = 3;
    localparam int DEF_SERVE_FRAMES = 60;

endpackage

`default_nettype wire

// File: rtl/game_ctrl_btn_cond.sv
// ============================================================================
// Module   : btn_cond
// Purpose  : 2-flop synchroniser, frame-sampled 2-sample debounce, rise pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_cond (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic sample_i,
    output logic db_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic samp_q;
    logic db_q;
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            samp_q  <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sample_i) begin
                samp_q <= sync2_q;
                // Two agreeing samples flip the debounced level; disagreement holds it.
                if (sync2_q && samp_q) begin
                    db_q   <= 1'b1;
                    rise_q <= ~db_q;
                end else if (!sync2_q && !samp_q) begin
                    db_q   <= 1'b0;
                end
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// Module   : game_ctrl
// Purpose  : Frame strobe, button conditioning and serve/play/miss/over FSM.
//            Define GAME_CTRL_PAUSE_EN to enable start-button pause in PLAY.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = DEF_LIVES_INIT,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int SCORE_W      = 8,
    parameter int LIVES_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    input  logic               ball_hit,
    input  logic               ball_miss,
    output logic               update,
    output logic               left,
    output logic               right,
    output logic               ball_hold,
    output logic               ball_run,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state
);

    localparam int                 CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

    logic vs_s1_q, vs_s2_q, vs_s3_q, update_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            vs_s3_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            vs_s1_q  <= vsync;
            vs_s2_q  <= vs_s1_q;
            vs_s3_q  <= vs_s2_q;
            update_q <= vs_s2_q & ~vs_s3_q;
        end
    end

    logic db_left, db_right, start_press;
    logic w_unused_rise_left, w_unused_rise_right, w_unused_db_start;

    btn_cond u_btn_left (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_left),
        .sample_i (update_q),
        .db_o     (db_left),
        .rise_o   (w_unused_rise_left)
    );

    btn_cond u_btn_right (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_right),
        .sample_i (update_q),
        .db_o     (db_right),
        .rise_o   (w_unused_rise_right)
    );

    btn_cond u_btn_start (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_start),
        .sample_i (update_q),
        .db_o     (w_unused_db_start),
        .rise_o   (start_press)
    );

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lives_q <= LIVES_LOAD;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lives_q <= lives_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lives_d = lives_q;
        score_d = score_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_press) begin
                    state_d = ST_SERVE;
                    cnt_d   = SERVE_LOAD;
                    lives_d = LIVES_LOAD;
                    score_d = '0;
                end
            end
            ST_SERVE: begin
                if (update_q) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                // A miss in the same cycle as a hit takes priority and scores nothing.
                if (ball_miss) begin
                    state_d = ST_MISS;
                end else begin
                    if (ball_hit && (score_q != '1)) begin
                        score_d = score_q + SCORE_W'(1);
                    end
`ifdef GAME_CTRL_PAUSE_EN
                    if (start_press) begin
                        state_d = ST_PAUSE;
                    end
`endif
                end
            end
            ST_MISS: begin
                lives_d = lives_q - LIVES_W'(1);
                if (lives_q == LIVES_W'(1)) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_SERVE;
                    cnt_d   = SERVE_LOAD;
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (start_press) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    logic dir_en;
    assign dir_en    = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign left      = dir_en & db_left & ~db_right;
    assign right     = dir_en & db_right & ~db_left;
    assign ball_run  = (state_q == ST_PLAY);
    assign ball_hold = (state_q != ST_PLAY) && (state_q != ST_PAUSE);
    assign update    = update_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Directed self-checking bench for game_ctrl (SERVE_FRAMES=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs_en, vs_gen, vs_man;
    logic       btn_left, btn_right, btn_start, ball_hit, ball_miss;
    logic       update, left, right, ball_hold, ball_run;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;
    logic       vsync;

    int n_chk  = 0;
    int n_fail = 0;

    assign vsync = vs_en ? vs_gen : vs_man;

    game_ctrl #(
        .LIVES_INIT   (3),
        .SERVE_FRAMES (4),
        .SCORE_W      (8),
        .LIVES_W      (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_start (btn_start),
        .ball_hit  (ball_hit),
        .ball_miss (ball_miss),
        .update    (update),
        .left      (left),
        .right     (right),
        .ball_hold (ball_hold),
        .ball_run  (ball_run),
        .lives     (lives),
        .score     (score),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Scaled frame: 32 clk period, vsync high for 8 clk.
    initial begin
        vs_gen = 1'b0;
        wait (vs_en);
        forever begin
            repeat (24) @(negedge clk);
            vs_gen = 1'b1;
            repeat (8) @(negedge clk);
            vs_gen = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge at which the n-th update strobe is seen.
    task automatic wait_upd(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (update) got++;
        end
        chk("wait_upd", got, n);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int cyc = 0;
        while (state !== s && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_state", state, s);
    endtask

    task automatic pulse_miss();
        ball_miss = 1'b1;
        tick(1);
        ball_miss = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vs_en = 1'b0; vs_man = 1'b0;
        btn_left = 0; btn_right = 0; btn_start = 0; ball_hit = 0; ball_miss = 0;
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_hold", ball_hold, 1);
        chk("rst_run", ball_run, 0);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_update", update, 0);
        chk("rst_lr", {left, right}, 0);
        rst = 1'b0;
        tick(3);

        // update is exactly one clk, 3 clk after the vsync rise
        vs_man = 1'b1;
        tick(1); chk("upd_c1", update, 0);
        tick(1); chk("upd_c2", update, 0);
        tick(1); chk("upd_c3", update, 1);
        tick(1); chk("upd_c4", update, 0);
        vs_man = 1'b0;
        tick(2);
        vs_en = 1'b1;
        tick(2);

        // Start press: SERVE after the 2nd frame sample
        btn_start = 1'b1;
        wait_upd(1); tick(2);
        chk("idle_after_s1", state, 0);
        wait_upd(1);
        tick(1); chk("idle_pulse_cyc", state, 0);
        tick(1); chk("serve_entry", state, 1);
        chk("serve_lives", lives, 3);
        chk("serve_lr", {left, right}, 0);

        // PLAY exactly 4 updates after entering SERVE
        wait_upd(1);
        btn_start = 1'b0;
        tick(2); chk("serve_u1", state, 1);
        wait_upd(2); tick(2); chk("serve_u3", state, 1);
        wait_upd(1);
        chk("serve_u4_state", state, 1);
        chk("serve_u4_hold", {ball_hold, ball_run}, 2'b10);
        tick(1);
        chk("play_entry", state, 2);
        chk("play_hold_run", {ball_hold, ball_run}, 2'b01);
        tick(2);

        // Arbitration
        btn_left = 1'b1; btn_right = 1'b1;
        wait_upd(3); tick(2);
        chk("both_lr", {left, right}, 0);
        btn_right = 1'b0;
        wait_upd(1); tick(2);
        chk("left_one_sample", {left, right}, 0);
        wait_upd(1); tick(2);
        chk("left_two_samples", {left, right}, 2'b10);
        btn_left = 1'b0;
        wait_upd(2); tick(2);
        chk("left_released", {left, right}, 0);

        // Score and saturation
        for (int i = 0; i < 255; i++) begin
            ball_hit = 1'b1; tick(1);
            ball_hit = 1'b0; tick(1);
            if (i == 0) chk("score_first", score, 1);
        end
        chk("score_255", score, 255);
        ball_hit = 1'b1; tick(1); ball_hit = 1'b0; tick(1);
        chk("score_sat", score, 255);

        // Hit and miss together: miss wins
        ball_hit = 1'b1; ball_miss = 1'b1; tick(1);
        ball_hit = 1'b0; ball_miss = 1'b0;
        chk("hm_state", state, 3);
        chk("hm_score", score, 255);
        tick(1);
        chk("miss1_state", state, 1);
        chk("miss1_lives", lives, 2);

        wait_state(2);
        pulse_miss();
        chk("miss2_miss", state, 3);
        tick(1);
        chk("miss2_state", state, 1);
        chk("miss2_lives", lives, 1);

        wait_state(2);
        pulse_miss();
        tick(1);
        chk("over_state", state, 4);
        chk("over_lives", lives, 0);
        chk("over_score", score, 255);
        chk("over_hold_run", {ball_hold, ball_run}, 2'b10);
        ball_hit = 1'b1; tick(1); ball_hit = 1'b0; tick(1);
        chk("over_hit_ignored", score, 255);

        // Direction forced off outside SERVE/PLAY
        wait_upd(1); tick(2);
        btn_left = 1'b1;
        wait_upd(3); tick(2);
        chk("over_left", {left, right}, 0);
        btn_left = 1'b0;
        wait_upd(2); tick(2);

        // Restart from OVER
        btn_start = 1'b1;
        wait_state(1);
        chk("restart_lives", lives, 3);
        chk("restart_score", score, 0);
        btn_start = 1'b0;
        wait_upd(2);
        wait_state(2);
        tick(2);

        // Start press while playing
        btn_start = 1'b1;
        wait_upd(2); tick(2);
`ifdef GAME_CTRL_PAUSE_EN
        chk("pause_state", state, 5);
        chk("pause_hold_run", {ball_hold, ball_run}, 2'b00);
        btn_start = 1'b0;
        wait_upd(2); tick(2);
        pulse_miss();
        tick(1);
        chk("pause_miss_ignored", state, 5);
        btn_start = 1'b1;
        wait_upd(2); tick(2);
        chk("unpause_state", state, 2);
`else
        chk("start_in_play", state, 2);
`endif
        btn_start = 1'b0;
        wait_upd(2);

        // Reset mid-game while update is high
        wait_upd(1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_update", update, 0);
        chk("midrst_state", state, 0);
        chk("midrst_hold", ball_hold, 1);
        chk("midrst_lives", lives, 3);
        tick(2);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
